// File: rtl/wtg_predictor.sv
// Direct-mapped branch predictor with per-entry saturating counters and targets.
// Also resolves control transfers and emits a registered redirect on mispredict.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 32
`endif
`ifndef WTG_OP_BIT
`define WTG_OP_BIT 4
`define WTG_OP_NOP  4'd0
`define WTG_OP_J26  4'd1
`define WTG_OP_J32  4'd2
`define WTG_OP_BEQ  4'd3
`define WTG_OP_BNE  4'd4
`define WTG_OP_BLTZ 4'd5
`define WTG_OP_BLEZ 4'd6
`define WTG_OP_BGTZ 4'd7
`define WTG_OP_BGEZ 4'd8
`endif

module wtg_predictor #(
  parameter int ADDR_BIT = `IM_ADDR_BIT,
  parameter int ENTRIES  = 16,
  parameter int CTR_BIT  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_BIT-1:0]    fetch_pc,
  output logic                   pred_taken,
  output logic [ADDR_BIT-1:0]    pred_target,
  input  logic                   res_valid,
  input  logic [`WTG_OP_BIT-1:0] res_op,
  input  logic [ADDR_BIT-1:0]    res_pc,
  input  logic [ADDR_BIT-1:0]    res_pc_4,
  input  logic [ADDR_BIT-1:0]    res_imm,
  input  logic signed [31:0]     res_x,
  input  logic signed [31:0]     res_y,
  input  logic                   res_pred_taken,
  input  logic [ADDR_BIT-1:0]    res_pred_target,
  output logic                   redirect,
  output logic [ADDR_BIT-1:0]    redirect_pc,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispred
);

  localparam int IDX     = $clog2(ENTRIES);
  localparam int TAG_BIT = ADDR_BIT - IDX - 2;
  localparam logic [CTR_BIT-1:0] CTR_MAX = {CTR_BIT{1'b1}};
  localparam logic [CTR_BIT-1:0] CTR_WT  = CTR_BIT'(1) << (CTR_BIT - 1);
  localparam logic [CTR_BIT-1:0] CTR_WNT = CTR_WT - CTR_BIT'(1);

  logic                valid_q [ENTRIES];
  logic                valid_d [ENTRIES];
  logic [TAG_BIT-1:0]  tag_q   [ENTRIES];
  logic [TAG_BIT-1:0]  tag_d   [ENTRIES];
  logic [ADDR_BIT-1:0] tgt_q   [ENTRIES];
  logic [ADDR_BIT-1:0] tgt_d   [ENTRIES];
  logic [CTR_BIT-1:0]  ctr_q   [ENTRIES];
  logic [CTR_BIT-1:0]  ctr_d   [ENTRIES];

  logic                redirect_q, redirect_d;
  logic [ADDR_BIT-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]         stat_branches_q, stat_branches_d;
  logic [31:0]         stat_mispred_q, stat_mispred_d;

  // Lookup: reads only registered state, so a same-cycle update is not bypassed.
  logic [IDX-1:0]     fetch_idx;
  logic [TAG_BIT-1:0] fetch_tag;
  logic               fetch_hit;

  always_comb begin
    fetch_idx   = fetch_pc[IDX+1:2];
    fetch_tag   = fetch_pc[ADDR_BIT-1:IDX+2];
    fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pred_taken  = fetch_hit && ctr_q[fetch_idx][CTR_BIT-1];
    pred_target = fetch_hit ? tgt_q[fetch_idx] : fetch_pc + ADDR_BIT'(4);
  end

  // Resolution of the instruction presented on the res_* bus.
  logic                is_xfer;
  logic                taken;
  logic [ADDR_BIT-1:0] target;
  logic [ADDR_BIT-1:0] actual_next;
  logic                mispred;
  logic                x_neg, x_zero;

  always_comb begin
    x_neg   = res_x[31];
    x_zero  = (res_x == 32'sd0);
    is_xfer = 1'b1;
    taken   = 1'b0;
    target  = res_imm + res_pc_4;
    case (res_op)
      `WTG_OP_J26: begin
        taken  = 1'b1;
        target = res_imm;
      end
      `WTG_OP_J32: begin
        taken  = 1'b1;
        target = res_x[ADDR_BIT-1:0];
      end
      `WTG_OP_BEQ:  taken = (res_x == res_y);
      `WTG_OP_BNE:  taken = (res_x != res_y);
      `WTG_OP_BLTZ: taken = x_neg;
      `WTG_OP_BLEZ: taken = x_neg || x_zero;
      `WTG_OP_BGTZ: taken = !x_neg && !x_zero;
      `WTG_OP_BGEZ: taken = !x_neg;
      default:      is_xfer = 1'b0;
    endcase
    actual_next = taken ? target : res_pc_4;
    mispred     = res_valid && is_xfer &&
                  ((taken != res_pred_taken) || (taken && (res_pred_target != target)));
  end

  // Table update for the resolving entry.
  logic [IDX-1:0]     res_idx;
  logic [TAG_BIT-1:0] res_tag;
  logic               res_hit;
  logic               do_update;

  always_comb begin
    res_idx   = res_pc[IDX+1:2];
    res_tag   = res_pc[ADDR_BIT-1:IDX+2];
    res_hit   = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    do_update = res_valid && is_xfer;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i] = valid_q[i];
      tag_d[i]   = tag_q[i];
      tgt_d[i]   = tgt_q[i];
      ctr_d[i]   = ctr_q[i];
    end
    if (do_update) begin
      if (res_hit) begin
        if (taken) begin
          tgt_d[res_idx] = target;
          if (ctr_q[res_idx] != CTR_MAX)
            ctr_d[res_idx] = ctr_q[res_idx] + CTR_BIT'(1);
        end else if (ctr_q[res_idx] != '0) begin
          ctr_d[res_idx] = ctr_q[res_idx] - CTR_BIT'(1);
        end
      end else if (taken) begin
        // Tag mismatch on an aliased index simply evicts the resident entry.
        valid_d[res_idx] = 1'b1;
        tag_d[res_idx]   = res_tag;
        tgt_d[res_idx]   = target;
        ctr_d[res_idx]   = CTR_WT;
      end
    end
  end

  always_comb begin
    redirect_d      = mispred;
    redirect_pc_d   = mispred ? actual_next : redirect_pc_q;
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (do_update && (stat_branches_q != 32'hFFFF_FFFF))
      stat_branches_d = stat_branches_q + 32'd1;
    if (mispred && (stat_mispred_q != 32'hFFFF_FFFF))
      stat_mispred_d = stat_mispred_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
      redirect_q      <= 1'b0;
      redirect_pc_q   <= '0;
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= valid_d[i];
        tag_q[i]   <= tag_d[i];
        tgt_q[i]   <= tgt_d[i];
        ctr_q[i]   <= ctr_d[i];
      end
      redirect_q      <= redirect_d;
      redirect_pc_q   <= redirect_pc_d;
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_wtg_predictor.sv
// Directed bench for wtg_predictor: lookup, training, resolution, aliasing, stats, reset.
`timescale 1ns/1ps
module tb_wtg_predictor;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_J26  = 4'd1;
  localparam logic [3:0] OP_J32  = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_BNE  = 4'd4;
  localparam logic [3:0] OP_BLTZ = 4'd5;
  localparam logic [3:0] OP_BLEZ = 4'd6;
  localparam logic [3:0] OP_BGTZ = 4'd7;
  localparam logic [3:0] OP_BGEZ = 4'd8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        fetch_pc = '0;
  logic               pred_taken;
  logic [31:0]        pred_target;
  logic               res_valid = 1'b0;
  logic [3:0]         res_op = OP_NOP;
  logic [31:0]        res_pc = '0, res_pc_4 = 32'd4, res_imm = '0;
  logic signed [31:0] res_x = '0, res_y = '0;
  logic               res_pred_taken = 1'b0;
  logic [31:0]        res_pred_target = '0;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [31:0]        stat_branches, stat_mispred;

  int errors = 0;
  int checks = 0;

  wtg_predictor #(.ADDR_BIT(32), .ENTRIES(16), .CTR_BIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .res_valid(res_valid), .res_op(res_op),
    .res_pc(res_pc), .res_pc_4(res_pc_4), .res_imm(res_imm), .res_x(res_x),
    .res_y(res_y), .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm,
                       input logic signed [31:0] x, input logic signed [31:0] y,
                       input logic pt, input logic [31:0] ptgt);
    @(negedge clk);
    res_valid = 1'b1; res_op = op; res_pc = pc; res_pc_4 = pc + 32'd4; res_imm = imm;
    res_x = x; res_y = y; res_pred_taken = pt; res_pred_target = ptgt;
    $display("res op=%0d pc=%h imm=%h x=%0d y=%0d pt=%0d ptgt=%h", op, pc, imm, x, y, pt, ptgt);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    res_valid = 1'b0; res_op = OP_NOP;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch_pc = 32'h40; #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%0d exp=0", redirect); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    checks++; if (stat_branches !== 32'h0 || stat_mispred !== 32'h0) begin errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispred); end
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin errors++; $display("FAIL reset_lookup got=%0d/%h exp=0/44", pred_taken, pred_target); end
  endtask

  task automatic test_beq_cold();
    drive(OP_BEQ, 32'h40, 32'h10, 5, 5, 1'b0, 32'h0);
    tick();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h54) begin errors++; $display("FAIL beq_cold_redirect got=%0d/%h exp=1/54", redirect, redirect_pc); end
    fetch_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h54) begin errors++; $display("FAIL beq_cold_lookup got=%0d/%h exp=1/54", pred_taken, pred_target); end
    tick();
    checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h54) begin errors++; $display("FAIL redirect_one_cycle got=%0d/%h exp=0/54", redirect, redirect_pc); end
  endtask

  task automatic test_beq_train();
    drive(OP_BEQ, 32'h40, 32'h10, 1, 2, 1'b1, 32'h54);
    tick();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h44) begin errors++; $display("FAIL beq_nt1_redirect got=%0d/%h exp=1/44", redirect, redirect_pc); end
    fetch_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h54) begin errors++; $display("FAIL beq_ctr01_lookup got=%0d/%h exp=0/54", pred_taken, pred_target); end
    drive(OP_BEQ, 32'h40, 32'h10, 1, 2, 1'b1, 32'h54);
    tick();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h44) begin errors++; $display("FAIL beq_nt2_redirect got=%0d/%h exp=1/44", redirect, redirect_pc); end
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL beq_ctr00_lookup got=%0d exp=0", pred_taken); end
  endtask

  task automatic test_signed_branches();
    logic [3:0]         ops [8];
    logic signed [31:0] xs  [8];
    logic               exp_t [8];
    logic [31:0]        pc;
    ops = '{OP_BLEZ, OP_BGTZ, OP_BGEZ, OP_BLEZ, OP_BGTZ, OP_BGEZ, OP_BLTZ, OP_BNE};
    xs  = '{0, 0, 0, -1, -1, -1, 0, 3};
    exp_t = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      pc = 32'h104 + 32'(4 * i);
      drive(ops[i], pc, 32'h20, xs[i], 4, 1'b0, 32'h0);
      tick();
      checks++;
      if (redirect !== exp_t[i] || (exp_t[i] && redirect_pc !== pc + 32'h24)) begin
        errors++;
        $display("FAIL branch_cond_%0d got=%0d/%h exp=%0d/%h", i, redirect, redirect_pc, exp_t[i], pc + 32'h24);
      end
    end
    drive(OP_NOP, 32'h40, 32'h10, 5, 5, 1'b1, 32'h99);
    tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL nop_no_redirect got=%0d exp=0", redirect); end
  endtask

  task automatic test_j32();
    drive(OP_J32, 32'h80, 32'h0, 32'sh200, 0, 1'b1, 32'h200);
    tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL j32_first_redirect got=%0d exp=0", redirect); end
    fetch_pc = 32'h80; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin errors++; $display("FAIL j32_first_lookup got=%0d/%h exp=1/200", pred_taken, pred_target); end
    drive(OP_J32, 32'h80, 32'h0, 32'sh300, 0, 1'b1, 32'h200);
    tick();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h300) begin errors++; $display("FAIL j32_second_redirect got=%0d/%h exp=1/300", redirect, redirect_pc); end
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin errors++; $display("FAIL j32_second_lookup got=%0d/%h exp=1/300", pred_taken, pred_target); end
  endtask

  task automatic test_alias();
    fetch_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin errors++; $display("FAIL alias_evicted got=%0d/%h exp=0/44", pred_taken, pred_target); end
    drive(OP_J26, 32'h40, 32'h100, 0, 0, 1'b1, 32'h100);
    #1;
    checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL no_bypass got=%h exp=44", pred_target); end
    tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL j26_redirect got=%0d exp=0", redirect); end
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin errors++; $display("FAIL j26_lookup got=%0d/%h exp=1/100", pred_taken, pred_target); end
    fetch_pc = 32'h80; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h84) begin errors++; $display("FAIL alias_80_evicted got=%0d/%h exp=0/84", pred_taken, pred_target); end
  endtask

  task automatic test_stats();
    checks++; if (stat_branches !== 32'd14) begin errors++; $display("FAIL stat_branches got=%0d exp=14", stat_branches); end
    checks++; if (stat_mispred !== 32'd8) begin errors++; $display("FAIL stat_mispred got=%0d exp=8", stat_mispred); end
  endtask

  task automatic test_saturate_and_reset();
    @(negedge clk);
    force dut.stat_mispred_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_mispred_q;
    for (int i = 0; i < 3; i++) begin
      drive(OP_BEQ, 32'h200, 32'h10, 7, 7, 1'b0, 32'h0);
      tick();
      checks++; if (stat_mispred !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mispred_saturate_%0d got=%h exp=ffffffff", i, stat_mispred); end
    end
    checks++; if (stat_branches !== 32'd17) begin errors++; $display("FAIL stat_branches_17 got=%0d exp=17", stat_branches); end
    drive(OP_BEQ, 32'h200, 32'h10, 7, 7, 1'b0, 32'h0);
    #2; rst_n = 1'b0; #1;
    checks++; if (redirect !== 1'b0 || stat_mispred !== 32'h0 || stat_branches !== 32'h0) begin errors++; $display("FAIL async_reset got=%0d/%h/%h exp=0/0/0", redirect, stat_mispred, stat_branches); end
    @(posedge clk); #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_held_redirect got=%0d exp=0", redirect); end
    @(negedge clk);
    rst_n = 1'b1; res_valid = 1'b0; res_op = OP_NOP;
    @(posedge clk); #1;
    fetch_pc = 32'h40; #1;
    checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL post_reset_redirect got=%0d/%h exp=0/0", redirect, redirect_pc); end
    checks++; if (stat_mispred !== 32'h0 || stat_branches !== 32'h0) begin errors++; $display("FAIL post_reset_stats got=%h/%h exp=0/0", stat_mispred, stat_branches); end
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin errors++; $display("FAIL post_reset_lookup got=%0d/%h exp=0/44", pred_taken, pred_target); end
    drive(OP_BEQ, 32'h40, 32'h10, 5, 5, 1'b0, 32'h0);
    tick();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h54 || stat_mispred !== 32'd1) begin errors++; $display("FAIL cold_restart got=%0d/%h/%0d exp=1/54/1", redirect, redirect_pc, stat_mispred); end
  endtask

  initial begin
    test_reset();
    test_beq_cold();
    test_beq_train();
    test_signed_branches();
    test_j32();
    test_alias();
    test_stats();
    test_saturate_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wtg_predictor.md
WTG_PREDICTOR -- requirements
Module: wtg_predictor

Interface
REQ-001 Parameter ADDR_BIT, default `IM_ADDR_BIT, width of every PC/target/immediate port.
REQ-002 Parameter ENTRIES, default 16, number of predictor entries; power of two, >= 2; IDX = log2(ENTRIES).
REQ-003 Parameter CTR_BIT, default 2, width of each saturating direction counter; >= 1.
REQ-004 Derived field TAG_BIT = ADDR_BIT - IDX - 2; entry index = pc[IDX+1:2]; tag = pc[ADDR_BIT-1:IDX+2].
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 fetch_pc  in  ADDR_BIT  PC being fetched; lookup address.
REQ-008 pred_taken  out  1  combinational prediction for fetch_pc.
REQ-009 pred_target  out  ADDR_BIT  combinational predicted target for fetch_pc.
REQ-010 res_valid  in  1  a control-transfer instruction resolves this cycle.
REQ-011 res_op  in  `WTG_OP_BIT  WTG_OP_* code: NOP, J26, J32, BEQ, BNE, BLTZ, BLEZ, BGTZ, BGEZ.
REQ-012 res_pc, res_pc_4, res_imm  in  ADDR_BIT each  instruction PC, PC+4, decoded immediate.
REQ-013 res_x, res_y  in  32 each, signed  operand data.
REQ-014 res_pred_taken, res_pred_target  in  1, ADDR_BIT  prediction that was issued for this instruction at fetch.
REQ-015 redirect  out  1  registered; mispredict flush request.
REQ-016 redirect_pc  out  ADDR_BIT  registered; correct next PC when redirect=1.
REQ-017 stat_branches, stat_mispred  out  32 each  saturating event counters.

Function
REQ-018 Resolution (combinational, qualified by res_valid): J26 taken, target res_imm; J32 taken, target res_x[ADDR_BIT-1:0]; BEQ x==y; BNE x!=y; BLTZ x<0; BLEZ x<=0; BGTZ x>0; BGEZ x>=0 (signed); branch target res_imm+res_pc_4 mod 2^ADDR_BIT; NOP or unknown code = not a transfer, no state change.
REQ-019 Actual next PC = target if taken, else res_pc_4.
REQ-020 Mispredict = (taken != res_pred_taken) or (taken and res_pred_target != target).
REQ-021 redirect and redirect_pc register mispredict and actual next PC one cycle after res_valid; redirect=1 for exactly one cycle per mispredict; redirect_pc holds last value when redirect=0.
REQ-022 Lookup hit = valid[idx] and tag[idx]==fetch tag; pred_taken = hit and counter MSB=1; pred_target = stored target on hit, else fetch_pc+4.
REQ-023 Update on res_valid with transfer op, at the same edge: hit and taken -> counter +1 saturating at all-ones, target overwritten; hit and not taken -> counter -1 saturating at 0.
REQ-024 Miss and taken -> allocate: valid=1, tag written, target written, counter = weakly taken (MSB=1, rest 0); miss and not taken -> no allocation.
REQ-025 J26/J32 update like taken branches; J32 target overwritten each time.
REQ-026 Same-cycle lookup and update of one entry: lookup returns pre-update value (no bypass).
REQ-027 stat_branches +1 per valid transfer op; stat_mispred +1 per mispredict; both hold at 32'hFFFFFFFF.
REQ-028 Aliasing: a tag-mismatched allocation replaces the resident entry unconditionally.

Reset
REQ-029 rst_n=0 asynchronously: all valid bits 0, counters weakly not-taken (MSB=0, rest 1), targets 0, redirect=0, redirect_pc=0, stats=0.
REQ-030 Reset mid-operation discards any pending redirect; first edge after release behaves as cold start.

Verification
REQ-031 Cold BEQ at res_pc=0x40, imm=0x10, x=y=5, pred_taken=0 -> next cycle redirect=1, redirect_pc=0x54; fetch_pc=0x40 then gives pred_taken=1, pred_target=0x54.
REQ-032 Same BEQ resolved not-taken twice (x=1,y=2) -> counter 10->01->00; pred_taken=0; second resolution with pred_taken=1 flags redirect to 0x44.
REQ-033 BLEZ/BGTZ/BGEZ with x=0 and x=-1 -> taken sets {1,0,1} and {1,0,0}; BLTZ x=0 not taken.
REQ-034 J32 resolved twice at 0x80 with x=0x200 then 0x300, pred target 0x200 both times -> second redirects to 0x300; pred_target updates to 0x300.
REQ-035 ENTRIES=16: taken at 0x40 then taken at 0x80 (same index 0) -> 0x40 lookup misses, predicts 0x44.
REQ-036 Force stat_mispred near max, inject mispredicts -> holds 32'hFFFFFFFF; assert rst_n between res_valid and next edge -> redirect stays 0, all stats 0.
